mult16_arbiter: RTL

MULT16_ARBITER -- requirements
Module: mult16_arbiter

---
 rtl/mult16_arbiter.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mult16_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mult16_arbiter
//  Description : Two-requester round-robin arbiter feeding a 3-stage signed
//                16x16 multiplier (radix-4 Booth, carry-save compression,
//                final carry-propagate add). Valid/ready handshakes on both
//                sides; the entire pipeline freezes under output backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult16_arbiter #(
    parameter int unsigned LAT = 3   // accept-to-result depth; only 3 is legal
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_prod,
    output logic        out_id,
    output logic        idle
);

    // The pipeline holds at most one operation per stage.
    localparam logic [1:0] c_MAX_INFLIGHT = LAT[1:0];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        rr_q;
    logic        rr_d;
    logic [1:0]  inflight_q;
    logic [1:0]  inflight_d;

    logic        s1_valid_q;
    logic        s1_id_q;
    logic [15:0] s1_a_q;
    logic [15:0] s1_b_q;

    logic        s2_valid_q;
    logic        s2_id_q;
    logic [31:0] s2_sum_q;
    logic [31:0] s2_carry_q;

    logic        s3_valid_q;
    logic        s3_id_q;
    logic [31:0] s3_prod_q;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic        w_stall;
    logic        w_out_hs;
    logic        w_room;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_accept;
    logic        w_acc_id;
    logic [15:0] w_acc_a;
    logic [15:0] w_acc_b;
    logic [31:0] w_a_ext;
    logic [7:0][31:0] w_pp;
    logic [31:0] w_csa_sum;
    logic [31:0] w_csa_carry;
    logic [31:0] w_csa_tmp;
    logic [31:0] w_final_sum;

    // ------------------------------------------------------------------
    // Handshake and arbitration
    // ------------------------------------------------------------------
    // A result sitting in S3 that the consumer refuses freezes everything.
    assign w_stall  = s3_valid_q & ~out_ready;
    assign w_out_hs = s3_valid_q & out_ready;

    // Occupancy guard: with all three stages full a new operand can only
    // enter when S3 is emptied in the same cycle. This is implied by the
    // stall rule but kept explicit so the pipeline can never overfill.
    assign w_room   = (inflight_q != c_MAX_INFLIGHT) | w_out_hs;

    // rr names the favoured requester; a lone requester always wins.
    assign w_grant0 = req0_valid & (~req1_valid | ~rr_q);
    assign w_grant1 = req1_valid & (~req0_valid |  rr_q);

    // Ready is only offered to a requester that is already valid, and is
    // forced low while reset is held.
    assign req0_ready = w_grant0 & ~w_stall & w_room & ~rst;
    assign req1_ready = w_grant1 & ~w_stall & w_room & ~rst;

    assign w_accept = req0_ready | req1_ready;
    assign w_acc_id = req1_ready;
    assign w_acc_a  = req1_ready ? req1_a : req0_a;
    assign w_acc_b  = req1_ready ? req1_b : req0_b;

    // Pointer moves to the other requester after every accept.
    assign rr_d = w_accept ? ~w_acc_id : rr_q;

    // In-flight counter: simultaneous accept and hand-off cancel out.
    always_comb begin
        inflight_d = inflight_q;
        case ({w_accept, w_out_hs})
            2'b10:   inflight_d = inflight_q + 2'd1;
            2'b01:   inflight_d = inflight_q - 2'd1;
            default: inflight_d = inflight_q;
        endcase
    end

    // ------------------------------------------------------------------
    // S1 -> S2: radix-4 Booth partial products of the registered operands
    // ------------------------------------------------------------------
    assign w_a_ext = {{16{s1_a_q[15]}}, s1_a_q};

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_booth
        logic [2:0]  w_grp;
        logic [31:0] w_mag;
        logic        w_neg;

        // Each digit looks at two multiplier bits plus the bit below them;
        // the lowest digit uses an implicit zero below bit 0.
        if (gi == 0) begin : g_first
            assign w_grp = {s1_b_q[1], s1_b_q[0], 1'b0};
        end else begin : g_rest
            assign w_grp = s1_b_q[2*gi+1 : 2*gi-1];
        end

        // Decode the Booth digit {-2,-1,0,+1,+2} into magnitude and sign.
        always_comb begin
            w_mag = '0;
            w_neg = 1'b0;
            case (w_grp)
                3'b001, 3'b010: w_mag = w_a_ext;
                3'b011:         w_mag = w_a_ext << 1;
                3'b100: begin
                    w_mag = w_a_ext << 1;
                    w_neg = 1'b1;
                end
                3'b101, 3'b110: begin
                    w_mag = w_a_ext;
                    w_neg = 1'b1;
                end
                default: begin
                    w_mag = '0;
                    w_neg = 1'b0;
                end
            endcase
        end

        // Everything is computed modulo 2^32; the true product fits, so
        // wrap-around in the intermediate terms cancels out exactly.
        assign w_pp[gi] = (w_neg ? (~w_mag + 32'd1) : w_mag) << (2 * gi);
    end

    // Fold the eight partial products into one sum/carry pair with a chain
    // of 3:2 carry-save compressors.
    always_comb begin
        w_csa_sum   = w_pp[0];
        w_csa_carry = w_pp[1];
        w_csa_tmp   = '0;
        for (int i = 2; i < 8; i++) begin
            w_csa_tmp   = w_csa_sum ^ w_csa_carry ^ w_pp[i];
            w_csa_carry = ((w_csa_sum & w_csa_carry) |
                           (w_csa_sum & w_pp[i])     |
                           (w_csa_carry & w_pp[i])) << 1;
            w_csa_sum   = w_csa_tmp;
        end
    end

    // ------------------------------------------------------------------
    // S2 -> S3: carry-propagate resolution of the compressed pair
    // ------------------------------------------------------------------
    assign w_final_sum = s2_sum_q + s2_carry_q;

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    // Control state: stage valid bits shift together unless stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            rr_q       <= 1'b0;
            inflight_q <= 2'd0;
        end else begin
            if (!w_stall) begin
                s1_valid_q <= w_accept;
                s2_valid_q <= s1_valid_q;
                s3_valid_q <= s2_valid_q;
            end
            rr_q       <= rr_d;
            inflight_q <= inflight_d;
        end
    end

    // Datapath registers: each stage loads only when real data arrives, so
    // bubbles leave the previous contents untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_id_q    <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_id_q    <= 1'b0;
            s2_sum_q   <= '0;
            s2_carry_q <= '0;
            s3_id_q    <= 1'b0;
            s3_prod_q  <= '0;
        end else if (!w_stall) begin
            if (w_accept) begin
                s1_id_q <= w_acc_id;
                s1_a_q  <= w_acc_a;
                s1_b_q  <= w_acc_b;
            end
            if (s1_valid_q) begin
                s2_id_q    <= s1_id_q;
                s2_sum_q   <= w_csa_sum;
                s2_carry_q <= w_csa_carry;
            end
            if (s2_valid_q) begin
                s3_id_q   <= s2_id_q;
                s3_prod_q <= w_final_sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = s3_valid_q;
    assign out_prod  = s3_prod_q;
    assign out_id    = s3_id_q;
    assign idle      = (inflight_q == 2'd0);

endmodule
`default_nettype wire
